jtframe_z80_romslot: RTL

- Memory-side responder for the Z80 ROM wait protocol: consumes the CPU's rom_cs/address and returns rom_ok plus a data byte.
- Sits between the Z80 wrapper's wait-state generator and the SDRAM controller.
- Fetches 16-bit SDRAM words over a req/ack/dst handshake and serves bytes to the CPU.
- Keeps a one-word tagged cache so sequential opcode fetches within a word need no SDRAM access.

---
 rtl/jtframe_romslot_pkg.sv | 23 ++
 rtl/jtframe_romslot_line.sv | 37 +++
 rtl/jtframe_z80_romslot.sv | 170 +++++++++++++++++
 3 files changed

// File: rtl/jtframe_romslot_pkg.sv
// Shared types for the Z80 ROM slot: FSM state encoding and byte-lane selection.
package jtframe_romslot_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        REQ    = 3'd1,
        WAIT   = 3'd2,
        PFREQ  = 3'd3,
        PFWAIT = 3'd4
    } state_t;

    localparam int LANE_W = 8;

    // byte_hi=1 means an even CPU address reads the upper half of the word
    function automatic logic [LANE_W-1:0] lane_sel(
        input logic [2*LANE_W-1:0] word,
        input logic                a0,
        input logic                byte_hi
    );
        return (a0 ^ byte_hi) ? word[2*LANE_W-1:LANE_W] : word[LANE_W-1:0];
    endfunction

endpackage

// File: rtl/jtframe_romslot_line.sv
// One cached SDRAM word with tag and valid bit; the compare against the
// CPU word address is combinational so hits cost no cycles.
module jtframe_romslot_line #(
    parameter int DW = 16,
    parameter int TW = 14
)(
    input  logic          clk,
    input  logic          rst_n,
    input  logic          load,
    input  logic          clr,
    input  logic [DW-1:0] wdata,
    input  logic [TW-1:0] wtag,
    input  logic [TW-1:0] ctag,
    output logic [DW-1:0] word,
    output logic          hit
);
    logic [TW-1:0] tag_r;
    logic          valid_r;

    assign hit = valid_r & (tag_r == ctag);

    // Line storage; clr beats load so a word landing with an invalidate is lost.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            word    <= '0;
            tag_r   <= '0;
            valid_r <= 1'b0;
        end else if (clr) begin
            valid_r <= 1'b0;
        end else if (load) begin
            word    <= wdata;
            tag_r   <= wtag;
            valid_r <= 1'b1;
        end
    end

endmodule

// File: rtl/jtframe_z80_romslot.sv
// Z80 ROM responder with a one-word tagged cache in front of an SDRAM
// req/ack/dst port. Define JTFRAME_ROMSLOT_PREFETCH_EN for next-word prefetch.
module jtframe_z80_romslot
    import jtframe_romslot_pkg::*;
#(
    parameter int AW      = 15,
    parameter int DW      = 16,
    parameter int BYTE_HI = 0
)(
    input  logic          clk,
    input  logic          rst_n,
    input  logic          cs,
    input  logic [AW-1:0] addr,
    input  logic          inv,
    output logic [7:0]    dout,
    output logic          ok,
    output logic [AW-2:0] sdram_addr,
    output logic          sdram_req,
    input  logic          sdram_ack,
    input  logic          sdram_dst,
    input  logic [DW-1:0] sdram_data
);
    localparam int TW = AW - 1;

    state_t        state_r;
    logic          drop_r;
    logic [1:0]    rst_sync_r;
    logic          rst_int_n_s;
    logic [TW-1:0] ctag_s;
    logic          hit_s;
    logic          landing_s;
    logic          fill_s;
    logic          load_s;
    logic [DW-1:0] word_s;
    logic [DW-1:0] wdata_s;
    logic [TW-1:0] wtag_s;

    // Reset asserts immediately but releases only on a clock edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rst_sync_r <= 2'b00;
        end else begin
            rst_sync_r <= {rst_sync_r[0], 1'b1};
        end
    end

    assign rst_int_n_s = rst_sync_r[1];
    assign ctag_s      = addr[AW-1:1];
    assign landing_s   = sdram_dst & ((state_r == WAIT) | ((state_r == REQ) & sdram_ack));
    assign fill_s      = landing_s & ~drop_r & ~inv;

`ifdef JTFRAME_ROMSLOT_PREFETCH_EN
    logic          pf_hit_s;
    logic          pf_move_s;
    logic          pf_landing_s;
    logic          pf_fill_s;
    logic [DW-1:0] pf_word_s;

    assign pf_landing_s = sdram_dst & ((state_r == PFWAIT) | ((state_r == PFREQ) & sdram_ack));
    assign pf_fill_s    = pf_landing_s & ~drop_r & ~inv;
    // a pf hit implies pf_tag == ctag, so the main tag is taken from the CPU
    assign pf_move_s    = (state_r == IDLE) & cs & ~hit_s & pf_hit_s & ~inv;
    assign load_s       = fill_s | pf_move_s;
    assign wdata_s      = pf_move_s ? pf_word_s : sdram_data;
    assign wtag_s       = pf_move_s ? ctag_s : sdram_addr;

    jtframe_romslot_line #(.DW(DW), .TW(TW)) u_pf (
        .clk   (clk),
        .rst_n (rst_int_n_s),
        .load  (pf_fill_s),
        .clr   (inv),
        .wdata (sdram_data),
        .wtag  (sdram_addr),
        .ctag  (ctag_s),
        .word  (pf_word_s),
        .hit   (pf_hit_s)
    );
`else
    assign load_s  = fill_s;
    assign wdata_s = sdram_data;
    assign wtag_s  = sdram_addr;
`endif

    jtframe_romslot_line #(.DW(DW), .TW(TW)) u_main (
        .clk   (clk),
        .rst_n (rst_int_n_s),
        .load  (load_s),
        .clr   (inv),
        .wdata (wdata_s),
        .wtag  (wtag_s),
        .ctag  (ctag_s),
        .word  (word_s),
        .hit   (hit_s)
    );

    assign ok   = cs & hit_s;
    assign dout = lane_sel(word_s, addr[0], BYTE_HI != 0);

    // Request sequencer: one SDRAM transaction in flight, drop_r marks it stale.
    always_ff @(posedge clk or negedge rst_int_n_s) begin
        if (!rst_int_n_s) begin
            state_r    <= IDLE;
            drop_r     <= 1'b0;
            sdram_req  <= 1'b0;
            sdram_addr <= '0;
        end else begin
            case (state_r)
                IDLE: begin
                    if (cs && !hit_s) begin
                        sdram_req <= 1'b1;
`ifdef JTFRAME_ROMSLOT_PREFETCH_EN
                        if (pf_move_s) begin
                            sdram_addr <= ctag_s + TW'(1);
                            state_r    <= PFREQ;
                        end else begin
                            sdram_addr <= ctag_s;
                            state_r    <= REQ;
                        end
`else
                        sdram_addr <= ctag_s;
                        state_r    <= REQ;
`endif
                    end
                end
                REQ, WAIT: begin
                    if ((state_r == REQ) && sdram_ack) begin
                        sdram_req <= 1'b0;
                        state_r   <= WAIT;
                    end
                    if (landing_s) begin
                        drop_r <= 1'b0;
`ifdef JTFRAME_ROMSLOT_PREFETCH_EN
                        if (fill_s) begin
                            sdram_req  <= 1'b1;
                            sdram_addr <= sdram_addr + TW'(1);
                            state_r    <= PFREQ;
                        end else begin
                            state_r <= IDLE;
                        end
`else
                        state_r <= IDLE;
`endif
                    end else if (inv) begin
                        drop_r <= 1'b1;
                    end
                end
`ifdef JTFRAME_ROMSLOT_PREFETCH_EN
                PFREQ, PFWAIT: begin
                    if ((state_r == PFREQ) && sdram_ack) begin
                        sdram_req <= 1'b0;
                        state_r   <= PFWAIT;
                    end
                    if (pf_landing_s) begin
                        drop_r  <= 1'b0;
                        state_r <= IDLE;
                    end else if (inv) begin
                        drop_r <= 1'b1;
                    end
                end
`endif
                default: begin
                    state_r   <= IDLE;
                    drop_r    <= 1'b0;
                    sdram_req <= 1'b0;
                end
            endcase
        end
    end

endmodule
